reg_pipe: RTL and testbench



---
 rtl/reg_pipe_pkg.sv | 9 +
 rtl/reg_pipe_if.sv | 26 ++
 rtl/reg_stage.sv | 48 ++++
 rtl/reg_pipe.sv | 63 ++++++
 tb/tb_reg_pipe.sv | 179 +++++++++++++++++
 5 files changed

// File: rtl/reg_pipe_pkg.sv
// Shared helpers for the register-pipeline and FIFO family.
// cnt_w sizes an occupancy counter able to hold 0..depth inclusive.
package reg_pipe_pkg;

    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/reg_pipe_if.sv
// Handshake/data bundle for reg_pipe: the driver side is the master, the pipe is the slave.
interface reg_pipe_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 3
);
    import reg_pipe_pkg::*;

    logic                      en;
    logic                      sclr;
    logic [WIDTH-1:0]          d;
    logic                      d_vld;
    logic [WIDTH-1:0]          q;
    logic                      q_vld;
    logic [cnt_w(DEPTH)-1:0]   count;

    modport master (
        output en, sclr, d, d_vld,
        input  q, q_vld, count
    );

    modport slave (
        input  en, sclr, d, d_vld,
        output q, q_vld, count
    );

endinterface

// File: rtl/reg_stage.sv
// One pipeline stage: WIDTH-bit data register plus valid bit.
// Async power-on reset, sync flush (sclr) overriding the shift enable.
module reg_stage #(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    parameter bit               CLR_DATA  = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en_i,
    input  logic             sclr_i,
    input  logic [WIDTH-1:0] d_i,
    input  logic             vld_i,
    output logic [WIDTH-1:0] q_o,
    output logic             vld_o
);
    logic [WIDTH-1:0] data_q, data_d;
    logic             vld_q, vld_d;

    always_comb begin
        data_d = data_q;
        vld_d  = vld_q;
        if (sclr_i) begin
            vld_d = 1'b0;
            // With CLR_DATA=0 a flush only kills the valid bit; data keeps its last value.
            if (CLR_DATA) begin
                data_d = RESET_VAL;
            end
        end else if (en_i) begin
            data_d = d_i;
            vld_d  = vld_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q <= RESET_VAL;
            vld_q  <= 1'b0;
        end else begin
            data_q <= data_d;
            vld_q  <= vld_d;
        end
    end

    assign q_o   = data_q;
    assign vld_o = vld_q;

endmodule

// File: rtl/reg_pipe.sv
// DEPTH-stage register pipeline with per-stage valid and a registered occupancy count.
// Latency DEPTH enabled edges; en=0 stalls every stage, sclr flushes and wins over en.
module reg_pipe
    import reg_pipe_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter int               DEPTH     = 3,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    parameter bit               CLR_DATA  = 1'b1
) (
    input  logic      clk,
    input  logic      rst,
    reg_pipe_if.slave bus
);
    localparam int CW = cnt_w(DEPTH);

    logic [DEPTH:0][WIDTH-1:0] dat;
    logic [DEPTH:0]            vld;
    logic [CW-1:0]             count_q, count_d;

    assign dat[0] = bus.d;
    assign vld[0] = bus.d_vld;

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        reg_stage #(
            .WIDTH     (WIDTH),
            .RESET_VAL (RESET_VAL),
            .CLR_DATA  (CLR_DATA)
        ) u_stage (
            .clk    (clk),
            .rst    (rst),
            .en_i   (bus.en),
            .sclr_i (bus.sclr),
            .d_i    (dat[i]),
            .vld_i  (vld[i]),
            .q_o    (dat[i+1]),
            .vld_o  (vld[i+1])
        );
    end

    // Modular add-then-subtract is exact at full occupancy: the intermediate wrap cancels.
    always_comb begin
        count_d = count_q;
        if (bus.sclr) begin
            count_d = '0;
        end else if (bus.en) begin
            count_d = count_q + CW'(bus.d_vld) - CW'(vld[DEPTH]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign bus.q     = dat[DEPTH];
    assign bus.q_vld = vld[DEPTH];
    assign bus.count = count_q;

endmodule

// File: tb/tb_reg_pipe.sv
// Directed bench: three pipes (DEPTH=3 flush-clears-data, DEPTH=3 flush-keeps-data, DEPTH=1)
// share one stimulus; a scoreboard checks output order, direct checks cover count/reset/flush.
module tb_reg_pipe;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0, sclr = 1'b0, d_vld = 1'b0;
    logic [7:0] d = 8'h00;

    int n_chk  = 0;
    int n_fail = 0;

    logic [7:0] qa[$];
    logic [7:0] qb[$];
    logic [7:0] qc[$];

    always #5 clk = ~clk;

    reg_pipe_if #(.WIDTH(8), .DEPTH(3)) ifa ();
    reg_pipe_if #(.WIDTH(8), .DEPTH(3)) ifb ();
    reg_pipe_if #(.WIDTH(8), .DEPTH(1)) ifc ();

    assign ifa.en = en;  assign ifa.sclr = sclr;  assign ifa.d = d;  assign ifa.d_vld = d_vld;
    assign ifb.en = en;  assign ifb.sclr = sclr;  assign ifb.d = d;  assign ifb.d_vld = d_vld;
    assign ifc.en = en;  assign ifc.sclr = sclr;  assign ifc.d = d;  assign ifc.d_vld = d_vld;

    reg_pipe #(.WIDTH(8), .DEPTH(3), .RESET_VAL(8'hA5), .CLR_DATA(1'b1)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
    reg_pipe #(.WIDTH(8), .DEPTH(3), .RESET_VAL(8'hA5), .CLR_DATA(1'b0)) dut_b (.clk(clk), .rst(rst), .bus(ifb));
    reg_pipe #(.WIDTH(8), .DEPTH(1), .RESET_VAL(8'h00), .CLR_DATA(1'b1)) dut_c (.clk(clk), .rst(rst), .bus(ifc));

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Apply one cycle of inputs, then update the expected-output queues as of that edge.
    task automatic step(input logic e, input logic s, input logic [7:0] dd, input logic dv);
        en = e; sclr = s; d = dd; d_vld = dv;
        @(posedge clk);
        if (s) begin
            qa.delete(); qb.delete(); qc.delete();
        end else if (e && dv) begin
            qa.push_back(dd); qb.push_back(dd); qc.push_back(dd);
        end
        #1;
    endtask

    // Monitor: an output counts as new only after an edge that actually shifted.
    logic       shifted;
    logic [7:0] exp_v;
    always begin
        @(posedge clk);
        shifted = en && !sclr && !rst;
        @(negedge clk);
        if (shifted && ifa.q_vld) begin
            n_chk++;
            if (qa.size() == 0) begin
                n_fail++; $display("FAIL sb_a: got %0h, expected no output", ifa.q);
            end else begin
                exp_v = qa.pop_front();
                if (ifa.q !== exp_v) begin n_fail++; $display("FAIL sb_a: got %0h, expected %0h", ifa.q, exp_v); end
            end
        end
        if (shifted && ifb.q_vld) begin
            n_chk++;
            if (qb.size() == 0) begin
                n_fail++; $display("FAIL sb_b: got %0h, expected no output", ifb.q);
            end else begin
                exp_v = qb.pop_front();
                if (ifb.q !== exp_v) begin n_fail++; $display("FAIL sb_b: got %0h, expected %0h", ifb.q, exp_v); end
            end
        end
        if (shifted && ifc.q_vld) begin
            n_chk++;
            if (qc.size() == 0) begin
                n_fail++; $display("FAIL sb_c: got %0h, expected no output", ifc.q);
            end else begin
                exp_v = qc.pop_front();
                if (ifc.q !== exp_v) begin n_fail++; $display("FAIL sb_c: got %0h, expected %0h", ifc.q, exp_v); end
            end
        end
    end

    initial begin
        // Power-on reset
        @(posedge clk); @(posedge clk); #1;
        chk("rst_a_q", ifa.q, 8'hA5);
        chk("rst_a_vld", 8'(ifa.q_vld), 8'h0);
        chk("rst_a_cnt", 8'(ifa.count), 8'h0);
        chk("rst_c_q", ifc.q, 8'h00);
        rst = 1'b0;

        // DEPTH=1: q follows d one enabled edge later
        step(1, 0, 8'h5A, 1);
        chk("d1_q", ifc.q, 8'h5A);
        chk("d1_vld", 8'(ifc.q_vld), 8'h1);
        chk("d1_cnt", 8'(ifc.count), 8'h1);
        chk("d1_a_cnt", 8'(ifa.count), 8'h1);
        step(1, 0, 8'h00, 0);
        chk("d1_cnt_drop", 8'(ifc.count), 8'h0);
        chk("d1_vld_drop", 8'(ifc.q_vld), 8'h0);
        step(0, 1, 8'h00, 0);
        chk("clr_a_cnt", 8'(ifa.count), 8'h0);
        chk("clr_a_q", ifa.q, 8'hA5);

        // Streaming
        step(1, 0, 8'h01, 1); chk("str_cnt1", 8'(ifa.count), 8'h1); chk("str_vld1", 8'(ifa.q_vld), 8'h0);
        step(1, 0, 8'h02, 1); chk("str_cnt2", 8'(ifa.count), 8'h2); chk("str_vld2", 8'(ifa.q_vld), 8'h0);
        step(1, 0, 8'h03, 1); chk("str_cnt3", 8'(ifa.count), 8'h3); chk("str_q3", ifa.q, 8'h01);
        chk("str_vld3", 8'(ifa.q_vld), 8'h1);
        step(1, 0, 8'h04, 1); chk("str_cnt4", 8'(ifa.count), 8'h3); chk("str_q4", ifa.q, 8'h02);

        // Fill while full, then stall
        step(1, 0, 8'h10, 1); chk("full_q1", ifa.q, 8'h03);
        step(1, 0, 8'h20, 1); chk("full_q2", ifa.q, 8'h04);
        step(1, 0, 8'h30, 1); chk("full_q3", ifa.q, 8'h10); chk("full_cnt", 8'(ifa.count), 8'h3);
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 8'hFF, 1);
            chk("stall_q", ifa.q, 8'h10);
            chk("stall_cnt", 8'(ifa.count), 8'h3);
        end
        step(1, 0, 8'h00, 0); chk("drain_q1", ifa.q, 8'h20); chk("drain_cnt1", 8'(ifa.count), 8'h2);
        step(1, 0, 8'h00, 0); chk("drain_q2", ifa.q, 8'h30); chk("drain_cnt2", 8'(ifa.count), 8'h1);
        step(1, 0, 8'h00, 0); chk("drain_vld3", 8'(ifa.q_vld), 8'h0); chk("drain_cnt3", 8'(ifa.count), 8'h0);

        // Flush priority over en with valid input
        step(1, 0, 8'h41, 1); step(1, 0, 8'h42, 1); step(1, 0, 8'h43, 1);
        chk("pre_fl_b_q", ifb.q, 8'h41);
        step(1, 1, 8'h77, 1);
        chk("fl_a_q", ifa.q, 8'hA5);
        chk("fl_a_vld", 8'(ifa.q_vld), 8'h0);
        chk("fl_a_cnt", 8'(ifa.count), 8'h0);
        chk("fl_b_q", ifb.q, 8'h41);
        chk("fl_b_vld", 8'(ifb.q_vld), 8'h0);
        chk("fl_b_cnt", 8'(ifb.count), 8'h0);
        chk("fl_c_q", ifc.q, 8'h00);
        chk("fl_c_cnt", 8'(ifc.count), 8'h0);
        for (int i = 0; i < 3; i++) begin
            step(1, 0, 8'h00, 0);
            chk("fl_after_vld", 8'(ifa.q_vld), 8'h0);
        end

        // Bubbles pass through uncompressed
        step(1, 0, 8'h0A, 1); chk("bub_cnt1", 8'(ifa.count), 8'h1);
        step(1, 0, 8'h0B, 0); chk("bub_cnt2", 8'(ifa.count), 8'h1);
        step(1, 0, 8'h0C, 1); chk("bub_cnt3", 8'(ifa.count), 8'h2);
        chk("bub_q3", ifa.q, 8'h0A); chk("bub_vld3", 8'(ifa.q_vld), 8'h1);
        step(1, 0, 8'h00, 0); chk("bub_vld4", 8'(ifa.q_vld), 8'h0); chk("bub_cnt4", 8'(ifa.count), 8'h1);
        step(1, 0, 8'h00, 0); chk("bub_q5", ifa.q, 8'h0C); chk("bub_vld5", 8'(ifa.q_vld), 8'h1);
        step(1, 0, 8'h00, 0); chk("bub_cnt6", 8'(ifa.count), 8'h0);

        // Asynchronous reset mid-period with a full pipe
        step(1, 0, 8'h11, 1); step(1, 0, 8'h22, 1); step(1, 0, 8'h33, 1);
        chk("pre_rst_q", ifa.q, 8'h11);
        #2;
        rst = 1'b1;
        #1;
        qa.delete(); qb.delete(); qc.delete();
        chk("arst_a_q", ifa.q, 8'hA5);
        chk("arst_a_vld", 8'(ifa.q_vld), 8'h0);
        chk("arst_a_cnt", 8'(ifa.count), 8'h0);
        chk("arst_b_q", ifb.q, 8'hA5);
        chk("arst_c_q", ifc.q, 8'h00);
        chk("arst_c_cnt", 8'(ifc.count), 8'h0);
        en = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        step(1, 0, 8'h99, 1);
        chk("post_rst_cnt", 8'(ifa.count), 8'h1);
        chk("post_rst_c_q", ifc.q, 8'h99);

        step(0, 0, 8'h00, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
